// File: rtl/mem_stage_if.sv
// EX->MEM->WB bus for mem_stage: EX-stage inputs, pipeline controls, forwarding/branch/WB outputs.
// The master modport drives the EX side; the slave modport is the memory stage itself.
interface mem_stage_if;
   logic        stall_in;
   logic        flush_in;
   logic [31:0] ex_alu_result;
   logic        ex_zero;
   logic [31:0] ex_write_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        ex_branch;
   logic [31:0] ex_branch_target;
   logic [31:0] mem_alu_result;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic        pc_src;
   logic [31:0] branch_target;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        misalign_err;

   modport master (
      output stall_in, flush_in, ex_alu_result, ex_zero, ex_write_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
             ex_branch_target,
      input  mem_alu_result, mem_rd, mem_reg_write, pc_src, branch_target,
             wb_data, wb_rd, wb_reg_write, misalign_err
   );

   modport slave (
      input  stall_in, flush_in, ex_alu_result, ex_zero, ex_write_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
             ex_branch_target,
      output mem_alu_result, mem_rd, mem_reg_write, pc_src, branch_target,
             wb_data, wb_rd, wb_reg_write, misalign_err
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, word-addressed data memory, MEM/WB register, beq resolve.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses skip the store, load 0 and flag misalign_err.
module mem_stage #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);

   typedef struct packed {
      logic [31:0] alu_result;
      logic        zero;
      logic [31:0] write_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic [31:0] branch_target;
   } exm_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        reg_write;
   } mwb_t;

   exm_t        exm_q, exm_d;
   mwb_t        mwb_q, mwb_d;
   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];

   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       rd_word;
   logic [31:0]       load_val;
   logic              misaligned;
   logic              mem_we;

   assign word_idx = exm_q.alu_result[ADDR_W+1:2];
   assign rd_word  = mem_q[word_idx];

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned = (exm_q.mem_read | exm_q.mem_write) && (exm_q.alu_result[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign load_val = misaligned ? '0 : rd_word;
   assign mem_we   = exm_q.mem_write & ~bus.stall_in & ~misaligned;

   // Flush outranks stall for the registers; the store itself is still blocked by stall.
   always_comb begin
      exm_d = exm_q;
      if (bus.flush_in) begin
         exm_d = '0;
      end else if (!bus.stall_in) begin
         exm_d.alu_result    = bus.ex_alu_result;
         exm_d.zero          = bus.ex_zero;
         exm_d.write_data    = bus.ex_write_data;
         exm_d.rd            = bus.ex_rd;
         exm_d.reg_write     = bus.ex_reg_write;
         exm_d.mem_read      = bus.ex_mem_read;
         exm_d.mem_write     = bus.ex_mem_write;
         exm_d.mem_to_reg    = bus.ex_mem_to_reg;
         exm_d.branch        = bus.ex_branch;
         exm_d.branch_target = bus.ex_branch_target;
      end
   end

   always_comb begin
      mwb_d = mwb_q;
      if (bus.flush_in || !bus.stall_in) begin
         mwb_d.data      = exm_q.mem_to_reg ? load_val : exm_q.alu_result;
         mwb_d.rd        = exm_q.rd;
         mwb_d.reg_write = exm_q.reg_write;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (mem_we) begin
         mem_d[word_idx] = exm_q.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exm_q <= '0;
         mwb_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         exm_q <= exm_d;
         mwb_q <= mwb_d;
         mem_q <= mem_d;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (bus.flush_in || !bus.stall_in) begin
         misalign_d = misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign bus.misalign_err = misalign_q;
`else
   assign bus.misalign_err = 1'b0;
`endif

   assign bus.mem_alu_result = exm_q.alu_result;
   assign bus.mem_rd         = exm_q.rd;
   assign bus.mem_reg_write  = exm_q.reg_write;
   assign bus.pc_src         = exm_q.branch & exm_q.zero;
   assign bus.branch_target  = exm_q.branch_target;
   assign bus.wb_data        = mwb_q.data;
   assign bus.wb_rd          = mwb_q.rd;
   assign bus.wb_reg_write   = mwb_q.reg_write;

endmodule
